mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one word-organised instruction/data memory port between the instruction-fetch requester and the load/store requester of the multicycle RV32I core.
- Serialises accesses and arbitrates simultaneous requests round-robin.
- Absorbs a fixed memory read latency and blocks out-of-range accesses.
- Sits between the control FSM/datapath and the memory model: a combinational ROM today, a synchronous RAM later.

Parameters:
- MEM_LAT, 0, memory read latency in cycles after the issue cycle; legal range 0..3.
- MEM_WORDS, 128, memory depth in 32-bit words; legal byte addresses are 0 .. MEM_WORDS*4-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- if_req  input  1  fetch request; held high until if_done.
- if_addr  input  32  fetch byte address; bits [1:0] ignored.
- if_done  output  1  one-cycle pulse: fetch complete.
- if_rdata  output  32  fetched instruction; valid in the if_done cycle, held afterwards.
- if_err  output  1  qualifies if_done; address was out of range.
- d_req  input  1  data request; held high until d_done.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  32  data byte address; bits [1:0] ignored.
- d_wdata  input  32  store data.
- d_done  output  1  one-cycle pulse: data access complete.
- d_rdata  output  32  load data; valid in the d_done cycle, held afterwards.
- d_err  output  1  qualifies d_done; address was out of range.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write strobe; only ever high together with mem_en.
- mem_addr  output  32  byte address to memory, bits [1:0] forced to 0.
- mem_wdata  output  32  write data to memory.
- mem_rdata  input  32  read data from memory.
- busy  output  1  high in any state other than IDLE.
- gnt_data  output  1  owner of the current or last transaction: 1 = data, 0 = fetch.

Behaviour:
- Reset: synchronous, active-high.
  - State goes to IDLE.
  - All outputs reset to 0, including if_rdata and d_rdata.
  - last_grant register resets to data, so fetch wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Samples if_req and d_req.
  - If exactly one request is high, that requester is granted.
  - If both are high, the requester other than last_grant is granted, and last_grant is updated.
  - The granted requester's address, we and wdata are latched. Fetch always uses we = 0.
  - Out-of-range check: a latched address >= MEM_WORDS*4 is out of range. It sets an internal err flag and jumps directly to RESP. mem_en is never asserted for it.
  - Otherwise the FSM moves to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_en = 1; mem_addr, mem_we and mem_wdata come from the latched values.
  - A store commits in this cycle. A store never enters WAIT; it goes straight to RESP.
  - A load with MEM_LAT = 0 captures mem_rdata at the end of ISSUE and goes to RESP.
  - A load with MEM_LAT > 0 goes to WAIT.
- WAIT:
  - Counter runs MEM_LAT cycles; mem_en = 0 throughout.
  - mem_rdata is captured at the end of the cycle that is MEM_LAT cycles after ISSUE, then the FSM goes to RESP.
- RESP (1 cycle):
  - Pulses the granted requester's done output.
  - Drives the captured data, or 0 if err, on that requester's rdata.
  - Drives that requester's err output.
  - Next state is IDLE.
- Latency, with the request sampled in IDLE cycle T:
  - Load: done in cycle T+2+MEM_LAT.
  - Store: done in cycle T+2.
  - Out-of-range access: done in cycle T+1.
  - The next IDLE sample is in the cycle after RESP.
- Requester contract:
  - Hold req and address stable until done, and drop req in the done cycle.
  - A request raised while the FSM is not in IDLE waits; it is not lost.
  - A req still high in the cycle after done starts a new transaction.
- The non-granted requester's done, rdata and err outputs are untouched during the other requester's transaction.
- Reset mid-transaction: the FSM returns to IDLE and no done is pulsed. mem_en is 0 from the cycle after reset.
- Address arithmetic: unsigned 32-bit compare against MEM_WORDS*4. Address 0xFFFFFFFC is out of range and must not wrap.

Test Plan:
- MEM_LAT=0, ROM word 1 = 0x40110233. if_req with if_addr=0x4 sampled at T. Required: mem_en high at T+1 with mem_addr=0x4; if_done at T+2 with if_rdata=0x40110233 and if_err=0.
- First tie after reset: if_req (addr 0x0) and d_req (load, addr 0x8) both high. Required: fetch is served first (gnt_data=0), then data. On the next tie, fetch is granted first again (last_grant = data after the data transaction).
- MEM_LAT=2: store d_addr=0x8, d_wdata=0xA5A5A5A5. Required: mem_we=1 for exactly one cycle and d_done 2 cycles after the sample. A following load from 0x8 returns 0xA5A5A5A5 with d_done at T+4.
- Out of range with MEM_WORDS=128: if_addr=0x200. Required: no mem_en; if_done at T+1 with if_err=1 and if_rdata=0.
- Unaligned: d_addr=0x0000000B. Required: mem_addr=0x00000008.
- Reset asserted in WAIT (MEM_LAT=3). Required: no d_done, mem_en stays 0, busy=0 the cycle after reset, outputs 0. A fresh request then completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one word memory port between fetch and load/store; blocks out-of-range addresses.
// Done after 2+MEM_LAT cycles (load), 2 (store), 1 (out of range); requesters hold req until done, losers wait in IDLE.
module mem_port_arbiter #(
    parameter int MEM_LAT   = 0,
    parameter int MEM_WORDS = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        gnt_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS * 4);
    localparam logic [1:0]  LAT        = 2'(MEM_LAT);

    state_t      state;
    state_t      state_nxt;

    logic        last_grant;
    logic        gnt_q;
    logic [31:2] addr_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [1:0]  cnt_q;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;

    logic        any_req;
    logic        pick_data;
    logic [31:0] sel_addr;
    logic        sel_oor;
    logic        capture;

    // Grant selection: a lone request wins outright; on a tie the side not served last wins.
    always_comb begin
        pick_data = 1'b0;
        if (d_req && !if_req) begin
            pick_data = 1'b1;
        end else if (d_req && if_req) begin
            pick_data = ~last_grant;
        end
    end

    assign any_req  = if_req | d_req;
    assign sel_addr = pick_data ? d_addr : if_addr;
    assign sel_oor  = {1'b0, sel_addr} >= ADDR_LIMIT;
    assign capture  = ((state == ISSUE) && !we_q && (LAT == 2'd0)) ||
                      ((state == WAIT) && (cnt_q == LAT));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = sel_oor ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (we_q || (LAT == 2'd0)) begin
                    state_nxt = RESP;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == LAT) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_en    = (state == ISSUE);
        mem_we    = mem_en & we_q;
        mem_addr  = mem_en ? {addr_q, 2'b00} : 32'd0;
        mem_wdata = mem_en ? wdata_q : 32'd0;
        if_done   = (state == RESP) & ~gnt_q;
        d_done    = (state == RESP) & gnt_q;
        if_err    = if_done & err_q;
        d_err     = d_done & err_q;
        if_rdata  = if_rdata_q;
        d_rdata   = d_rdata_q;
        busy      = (state != IDLE);
        gnt_data  = gnt_q;
    end

    // last_grant resets to data so fetch wins the first tie; gnt_data itself resets to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            gnt_q      <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= 32'd0;
            err_q      <= 1'b0;
            cnt_q      <= 2'd0;
            if_rdata_q <= 32'd0;
            d_rdata_q  <= 32'd0;
        end else begin
            if ((state == IDLE) && any_req) begin
                last_grant <= pick_data;
                gnt_q      <= pick_data;
                addr_q     <= sel_addr[31:2];
                we_q       <= pick_data & d_we;
                wdata_q    <= pick_data ? d_wdata : 32'd0;
                err_q      <= sel_oor;
                if (sel_oor) begin
                    if (pick_data) begin
                        d_rdata_q <= 32'd0;
                    end else begin
                        if_rdata_q <= 32'd0;
                    end
                end
            end
            if (state == ISSUE) begin
                cnt_q <= 2'd1;
            end else if (state == WAIT) begin
                cnt_q <= cnt_q + 2'd1;
            end
            if (capture) begin
                if (gnt_q) begin
                    d_rdata_q <= mem_rdata;
                end else begin
                    if_rdata_q <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: three instances with MEM_LAT = 0, 2, 3.
module tb_mem_port_arbiter;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic        rst       [NI];
    logic        if_req    [NI];
    logic [31:0] if_addr   [NI];
    logic        if_done   [NI];
    logic [31:0] if_rdata  [NI];
    logic        if_err    [NI];
    logic        d_req     [NI];
    logic        d_we      [NI];
    logic [31:0] d_addr    [NI];
    logic [31:0] d_wdata   [NI];
    logic        d_done    [NI];
    logic [31:0] d_rdata   [NI];
    logic        d_err     [NI];
    logic        mem_en    [NI];
    logic        mem_we    [NI];
    logic [31:0] mem_addr  [NI];
    logic [31:0] mem_wdata [NI];
    logic [31:0] mem_rdata [NI];
    logic        busy      [NI];
    logic        gnt_data  [NI];

    int          en_cnt  [NI] = '{default: 0};
    int          we_cnt  [NI] = '{default: 0};
    int          en_cyc  [NI] = '{default: -1};
    logic [31:0] en_addr [NI] = '{default: 32'd0};

    generate
        for (genvar g = 0; g < NI; g++) begin : g_inst
            localparam int LAT = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
            logic [31:0] mem [128];
            logic [6:0]  la;
            int          since;

            // Memory model: read data is only valid exactly LAT cycles after the issue cycle.
            initial begin
                for (int i = 0; i < 128; i++) mem[i] = 32'hC0DE0000 + 32'(i);
                mem[1] = 32'h40110233;
                la    = 7'd0;
                since = 0;
                forever begin
                    @(posedge clk);
                    if (mem_en[g] === 1'b1) begin
                        la    <= mem_addr[g][8:2];
                        since <= 1;
                        if (mem_we[g] === 1'b1) mem[mem_addr[g][8:2]] <= mem_wdata[g];
                    end else if (since > 0 && since < 8) begin
                        since <= since + 1;
                    end
                end
            end

            assign mem_rdata[g] = (LAT == 0) ?
                ((mem_en[g] === 1'b1) ? mem[mem_addr[g][8:2]] : 32'hDEADBEEF) :
                ((since == LAT) ? mem[la] : 32'hDEADBEEF);

            always @(negedge clk) begin
                if (mem_en[g] === 1'b1) begin
                    en_cnt[g]  = en_cnt[g] + 1;
                    en_cyc[g]  = cyc;
                    en_addr[g] = mem_addr[g];
                end
                if (mem_we[g] === 1'b1) we_cnt[g] = we_cnt[g] + 1;
            end

            mem_port_arbiter #(.MEM_LAT(LAT), .MEM_WORDS(128)) u_dut (
                .clk       (clk),
                .reset     (rst[g]),
                .if_req    (if_req[g]),
                .if_addr   (if_addr[g]),
                .if_done   (if_done[g]),
                .if_rdata  (if_rdata[g]),
                .if_err    (if_err[g]),
                .d_req     (d_req[g]),
                .d_we      (d_we[g]),
                .d_addr    (d_addr[g]),
                .d_wdata   (d_wdata[g]),
                .d_done    (d_done[g]),
                .d_rdata   (d_rdata[g]),
                .d_err     (d_err[g]),
                .mem_en    (mem_en[g]),
                .mem_we    (mem_we[g]),
                .mem_addr  (mem_addr[g]),
                .mem_wdata (mem_wdata[g]),
                .mem_rdata (mem_rdata[g]),
                .busy      (busy[g]),
                .gnt_data  (gnt_data[g])
            );
        end
    endgenerate

    typedef struct {
        int          inst;
        bit          is_data;
        logic [31:0] rdata;
        bit          chk_rd;
        bit          err;
        int          at;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_resp(input int k, input bit isd, input logic [31:0] rd, input logic er);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: inst %0d data=%0d done at cycle %0d, required none", k, isd, cyc);
        end else begin
            e = sbq.pop_front();
            chk("resp_inst", k, e.inst);
            chk("resp_owner", {31'd0, isd}, {31'd0, e.is_data});
            if (e.chk_rd) chk("resp_rdata", rd, e.rdata);
            chk("resp_err", {31'd0, er}, {31'd0, e.err});
            chk("resp_cycle", cyc, e.at);
            chk("resp_gnt_data", {31'd0, gnt_data[k]}, {31'd0, e.is_data});
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected response.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (if_done[k] === 1'b1) check_resp(k, 1'b0, if_rdata[k], if_err[k]);
            if (d_done[k] === 1'b1)  check_resp(k, 1'b1, d_rdata[k], d_err[k]);
        end
    end

    task automatic push(input int k, input bit isd, input logic [31:0] rd, input bit chkrd,
                        input bit er, input int at);
        exp_t e;
        e.inst = k; e.is_data = isd; e.rdata = rd; e.chk_rd = chkrd; e.err = er; e.at = at;
        sbq.push_back(e);
    endtask

    // Drops each req in its done cycle, then returns on the next (idle) negedge.
    task automatic wait_done(input int k);
        int n = 0;
        while ((if_req[k] || d_req[k]) && n < 60) begin
            @(negedge clk);
            n++;
            if (if_done[k] === 1'b1) if_req[k] = 1'b0;
            if (d_done[k] === 1'b1)  d_req[k]  = 1'b0;
        end
        if (if_req[k] || d_req[k]) begin
            checks++;
            errors++;
            $display("FAIL timeout: inst %0d req pending after %0d cycles, required done", k, n);
            if_req[k] = 1'b0;
            d_req[k]  = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic fetch(input int k, input logic [31:0] a, input logic [31:0] rd,
                         input bit er, input int lat);
        if_addr[k] = a;
        if_req[k]  = 1'b1;
        push(k, 1'b0, rd, 1'b1, er, cyc + lat);
        wait_done(k);
    endtask

    task automatic data(input int k, input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input bit er, input int lat);
        d_we[k]    = we;
        d_addr[k]  = a;
        d_wdata[k] = wd;
        d_req[k]   = 1'b1;
        push(k, 1'b1, rd, !we, er, cyc + lat);
        wait_done(k);
    endtask

    task automatic tie(input int k, input logic [31:0] ia, input logic [31:0] da,
                       input bit data_first, input logic [31:0] ird, input logic [31:0] drd,
                       input int lat);
        if_addr[k] = ia;
        d_addr[k]  = da;
        d_we[k]    = 1'b0;
        if_req[k]  = 1'b1;
        d_req[k]   = 1'b1;
        if (data_first) begin
            push(k, 1'b1, drd, 1'b1, 1'b0, cyc + 2 + lat);
            push(k, 1'b0, ird, 1'b1, 1'b0, cyc + 5 + 2 * lat);
        end else begin
            push(k, 1'b0, ird, 1'b1, 1'b0, cyc + 2 + lat);
            push(k, 1'b1, drd, 1'b1, 1'b0, cyc + 5 + 2 * lat);
        end
        wait_done(k);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int t;
        int e0;
        int w0;
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1; if_req[k] = 1'b0; if_addr[k] = 32'd0;
            d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = 32'd0; d_wdata[k] = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("rst_busy", {31'd0, busy[k]}, 32'd0);
            chk("rst_gnt_data", {31'd0, gnt_data[k]}, 32'd0);
            chk("rst_mem_en", {31'd0, mem_en[k]}, 32'd0);
            chk("rst_if_rdata", if_rdata[k], 32'd0);
            chk("rst_d_rdata", d_rdata[k], 32'd0);
            chk("rst_mem_addr", mem_addr[k], 32'd0);
            rst[k] = 1'b0;
        end
        @(negedge clk);

        // LAT=0 fetch of word 1
        t = cyc;
        fetch(0, 32'h4, 32'h40110233, 1'b0, 2);
        chk("fetch_mem_en_cycle", en_cyc[0], t + 1);
        chk("fetch_mem_addr", en_addr[0], 32'h4);

        // LAT=2: first tie after reset goes to fetch, and again after the data transaction
        tie(1, 32'h0, 32'h8, 1'b0, 32'hC0DE0000, 32'hC0DE0002, 2);
        tie(1, 32'h10, 32'h14, 1'b0, 32'hC0DE0004, 32'hC0DE0005, 2);

        // LAT=2 store then load of the same word
        w0 = we_cnt[1];
        data(1, 1'b1, 32'h8, 32'hA5A5A5A5, 32'h0, 1'b0, 2);
        chk("store_we_pulses", we_cnt[1], w0 + 1);
        data(1, 1'b0, 32'h8, 32'h0, 32'hA5A5A5A5, 1'b0, 4);

        // LAT=0: last grant was fetch, so this tie goes to data first
        tie(0, 32'h8, 32'hC, 1'b1, 32'hC0DE0002, 32'hC0DE0003, 0);

        // Out-of-range: no memory access, done one cycle after the sample
        e0 = en_cnt[0];
        fetch(0, 32'h200, 32'h0, 1'b1, 1);
        data(0, 1'b0, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1, 1);
        data(0, 1'b1, 32'h200, 32'h12345678, 32'h0, 1'b1, 1);
        chk("oor_no_mem_en", en_cnt[0], e0);
        fetch(0, 32'h1FC, 32'hC0DE007F, 1'b0, 2);

        // Unaligned data address
        data(0, 1'b0, 32'hB, 32'h0, 32'hC0DE0002, 1'b0, 2);
        chk("unaligned_mem_addr", en_addr[0], 32'h8);

        // LAT=3: reset while in WAIT, then a fresh request
        e0 = en_cnt[2];
        d_we[2] = 1'b0; d_addr[2] = 32'hC; d_req[2] = 1'b1;
        repeat (3) @(negedge clk);
        chk("wait_busy", {31'd0, busy[2]}, 32'd1);
        rst[2] = 1'b1;
        @(negedge clk);
        d_req[2] = 1'b0;
        chk("midrst_busy", {31'd0, busy[2]}, 32'd0);
        chk("midrst_mem_en", {31'd0, mem_en[2]}, 32'd0);
        chk("midrst_d_done", {31'd0, d_done[2]}, 32'd0);
        chk("midrst_d_rdata", d_rdata[2], 32'd0);
        rst[2] = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst_mem_en_count", en_cnt[2], e0 + 1);
        data(2, 1'b0, 32'hC, 32'h0, 32'hC0DE0003, 1'b0, 5);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
